// File: rtl/inst_fetch_buffer.sv
// Instruction fetch front end: owns the fetch PC, issues in-order requests on the
// SRAM-like instruction bus and queues returned words with their PCs for decode.
// Latency: data_ok captured at edge N is presented on out_valid after edge N.
// Backpressure: out_ready low fills the ring; inst_req drops once every slot is
//   allocated or reserved for a stale response.
//
// Ports:
//   clk, resetn                   core clock, asynchronous active-low reset
//   inst_req/inst_addr            fetch request and word-aligned address
//   inst_addr_ok                  request accepted this cycle
//   inst_data_ok/inst_rdata       in-order response and its word
//   redirect/redirect_pc          flush the ring and restart fetch at redirect_pc
//   out_valid/out_ready           decode handshake for the head entry
//   out_instr/out_pc/out_adel     head entry payload
//
// Optional feature macro FETCH_ADEL_EN: a misaligned redirect_pc produces a single
// address-error entry instead of a bus request, and fetch halts until the next
// redirect. Without it the redirect target is silently word-aligned.
module inst_fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        out_adel
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   r_ent_pc    [DEPTH];
  logic [31:0]   r_ent_instr [DEPTH];
  logic [DEPTH-1:0] r_ent_filled;
`ifdef FETCH_ADEL_EN
  logic [DEPTH-1:0] r_ent_adel;
`endif
  logic [PW-1:0] r_head, r_fill, r_tail;
  logic [CW-1:0] r_alloc_cnt;  // entries allocated in the ring
  logic [CW-1:0] r_pend_cnt;   // allocated entries still waiting for their word
  logic [CW-1:0] r_drop_cnt;   // stale responses still to discard
  logic [31:0]   r_pc;
  logic          r_halted;
  logic          r_run;        // holds inst_req low until the first edge after reset

  logic [CW:0]   w_used;
  logic          w_accept, w_fill, w_drop, w_pop;
  logic [CW:0]   w_drop_sum;
  logic [31:0]   w_redir_pc;

  assign w_used    = {1'b0, r_alloc_cnt} + {1'b0, r_drop_cnt};
  assign inst_req  = r_run && !r_halted && (w_used < DEPTH_C);
  assign inst_addr = r_pc;

  assign w_accept = inst_req && inst_addr_ok;
  assign w_fill   = inst_data_ok && (r_drop_cnt == '0);
  assign w_drop   = inst_data_ok && (r_drop_cnt != '0);

  assign out_valid = (r_alloc_cnt != '0) && r_ent_filled[r_head];
  assign out_instr = r_ent_instr[r_head];
  assign out_pc    = r_ent_pc[r_head];
  assign w_pop     = out_valid && out_ready;
`ifdef FETCH_ADEL_EN
  assign out_adel  = r_ent_adel[r_head];
  assign w_redir_pc = redirect_pc;
`else
  assign out_adel  = 1'b0;
  assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;
`endif

  // Responses still owed by the bus after a redirect edge: everything unfilled,
  // everything already being dropped, plus a request accepted right now, minus a
  // response arriving right now (whether it would have been filled or dropped).
  assign w_drop_sum = {1'b0, r_pend_cnt} + {1'b0, r_drop_cnt}
                    + (CW + 1)'(w_accept) - (CW + 1)'(inst_data_ok);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ent_pc[i]    <= '0;
        r_ent_instr[i] <= '0;
      end
      r_ent_filled <= '0;
`ifdef FETCH_ADEL_EN
      r_ent_adel   <= '0;
`endif
      r_head      <= '0;
      r_fill      <= '0;
      r_tail      <= '0;
      r_alloc_cnt <= '0;
      r_pend_cnt  <= '0;
      r_drop_cnt  <= '0;
      r_pc        <= RESET_PC;
      r_halted    <= 1'b0;
      r_run       <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (redirect) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_ent_pc[i]    <= '0;
          r_ent_instr[i] <= '0;
        end
        r_ent_filled <= '0;
`ifdef FETCH_ADEL_EN
        r_ent_adel   <= '0;
`endif
        r_head      <= '0;
        r_fill      <= '0;
        r_tail      <= '0;
        r_alloc_cnt <= '0;
        r_pend_cnt  <= '0;
        r_drop_cnt  <= CW'(w_drop_sum);
        r_pc        <= w_redir_pc;
        r_halted    <= 1'b0;
`ifdef FETCH_ADEL_EN
        // Misaligned target: park a ready-made error entry in slot 0 and stop fetching.
        if (redirect_pc[1:0] != 2'b00) begin
          r_ent_pc[0]     <= redirect_pc;
          r_ent_filled[0] <= 1'b1;
          r_ent_adel[0]   <= 1'b1;
          r_tail          <= PW'(1);
          r_fill          <= PW'(1);
          r_alloc_cnt     <= CW'(1);
          r_halted        <= 1'b1;
        end
`endif
      end else begin
        // Accept, fill and pop always touch distinct slots: accept needs a free
        // slot, fill targets an allocated unfilled slot, pop a filled one.
        if (w_accept) begin
          r_ent_pc[r_tail]     <= r_pc;
          r_ent_instr[r_tail]  <= '0;
          r_ent_filled[r_tail] <= 1'b0;
`ifdef FETCH_ADEL_EN
          r_ent_adel[r_tail]   <= 1'b0;
`endif
          r_tail <= r_tail + 1'b1;
          r_pc   <= r_pc + 32'd4;
        end
        if (w_fill) begin
          r_ent_instr[r_fill]  <= inst_rdata;
          r_ent_filled[r_fill] <= 1'b1;
          r_fill <= r_fill + 1'b1;
        end
        if (w_drop) begin
          r_drop_cnt <= r_drop_cnt - 1'b1;
        end
        if (w_pop) begin
          r_ent_filled[r_head] <= 1'b0;
          r_head <= r_head + 1'b1;
        end
        r_alloc_cnt <= r_alloc_cnt + CW'(w_accept) - CW'(w_pop);
        r_pend_cnt  <= r_pend_cnt + CW'(w_accept) - CW'(w_fill);
      end
    end
  end

endmodule
